// File: rtl/conv_sched_if.sv
// Source-bank, BCD-converter and character-buffer signals of the scheduler.
// master: the scheduler side; slave: the source, converter and buffer side.
interface conv_sched_if #(
    parameter int WORDW = 10,
    parameter int ADDRW = 10
);
    logic             src_rd;
    logic [7:0]       src_addr;
    logic [WORDW-1:0] src_data;
    logic [9:0]       bcd_bin;
    logic [11:0]      bcd_dec;
    logic             buf_wr;
    logic [ADDRW-1:0] buf_addr;
    logic [3:0]       buf_data;
    logic             buf_ready;

    modport master (
        output src_rd, src_addr, bcd_bin, buf_wr, buf_addr, buf_data,
        input  src_data, bcd_dec, buf_ready
    );

    modport slave (
        input  src_rd, src_addr, bcd_bin, buf_wr, buf_addr, buf_data,
        output src_data, bcd_dec, buf_ready
    );
endinterface

// File: rtl/conv_sched.sv
// Frame scheduler: on a vsync rising edge, converts L source words to
// blanked/saturated digit codes and writes them into the character buffer.
// Ports: clk, RST (sync, active-high), vsync; bus (conv_sched_if.master:
// source read, BCD converter, buffer write); busy, done, overrun status.
module conv_sched #(
    parameter int L     = 10,
    parameter int WORDW = 10,
    parameter int HCHAR = 50,
    parameter int VCHAR = 18,
    parameter int ADDRW = 10
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          vsync,
    conv_sched_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam int WPR = HCHAR / 4;
    localparam logic [ADDRW-1:0] WPR_M1 = ADDRW'(WPR - 1);
    localparam logic [ADDRW-1:0] ROW_M1 = ADDRW'(VCHAR - 1);
    localparam logic [ADDRW-1:0] HCW    = ADDRW'(HCHAR);
    localparam logic [ADDRW-1:0] ONE    = ADDRW'(1);
    localparam logic [7:0]       KLAST  = 8'(L - 1);

    typedef enum logic [2:0] {
        IDLE, RD, LAT, W2, W1, W0, WSP, DONE
    } state_t;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic [7:0]       k_q;
    logic [ADDRW-1:0] wc_q, row_q, row_base_q, ptr_q;
    logic [3:0]       d2_q, d1_q, d0_q;
    logic             ovr_q;

    logic       start, wr_st, acc, sat;
    logic [3:0] h, t, u;

    assign start = vsync && !vsync_q;
    assign wr_st = (state_q == W2) || (state_q == W1) ||
                   (state_q == W0) || (state_q == WSP);
    assign acc   = wr_st && bus.buf_ready;

    assign h   = bus.bcd_dec[11:8];
    assign t   = bus.bcd_dec[7:4];
    assign u   = bus.bcd_dec[3:0];
    assign sat = int'(bus.src_data) > 999;

    always_ff @(posedge clk) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RD;
            RD:   state_d = LAT;
            LAT:  state_d = W2;
            W2:   if (acc) state_d = W1;
            W1:   if (acc) state_d = W0;
            W0:   if (acc) state_d = WSP;
            WSP:  if (acc) state_d = (k_q == KLAST) ? DONE : RD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            vsync_q    <= 1'b1;
            k_q        <= '0;
            wc_q       <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            ptr_q      <= '0;
            d2_q       <= '0;
            d1_q       <= '0;
            d0_q       <= '0;
            ovr_q      <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (start && state_q != IDLE) ovr_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    k_q        <= '0;
                    wc_q       <= '0;
                    row_q      <= '0;
                    row_base_q <= '0;
                    ptr_q      <= '0;
                end
                LAT: begin
                    d2_q <= sat ? 4'hE : (h == 4'd0 ? 4'hF : h);
                    d1_q <= sat ? 4'hE :
                            ((h == 4'd0 && t == 4'd0) ? 4'hF : t);
                    d0_q <= sat ? 4'hE : u;
                end
                W2, W1, W0: if (acc) ptr_q <= ptr_q + ONE;
                WSP: if (acc) begin
                    if (k_q != KLAST) k_q <= k_q + 8'd1;
                    // End of a row jumps to the next row base; the last
                    // row wraps back to the top and overwrites old words.
                    if (wc_q == WPR_M1) begin
                        wc_q <= '0;
                        if (row_q == ROW_M1) begin
                            row_q      <= '0;
                            row_base_q <= '0;
                            ptr_q      <= '0;
                        end else begin
                            row_q      <= row_q + ONE;
                            row_base_q <= row_base_q + HCW;
                            ptr_q      <= row_base_q + HCW;
                        end
                    end else begin
                        wc_q  <= wc_q + ONE;
                        ptr_q <= ptr_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.buf_data = 4'h0;
        unique case (1'b1)
            state_q == W2:  bus.buf_data = d2_q;
            state_q == W1:  bus.buf_data = d1_q;
            state_q == W0:  bus.buf_data = d0_q;
            state_q == WSP: bus.buf_data = 4'hF;
            default:        bus.buf_data = 4'h0;
        endcase
    end

    assign bus.src_rd   = state_q == RD;
    assign bus.src_addr = k_q;
    assign bus.bcd_bin  = 10'(bus.src_data);
    assign bus.buf_wr   = wr_st;
    assign bus.buf_addr = ptr_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: table frame, stall/overrun/reset sequences and
// random frames checked against a decimal-arithmetic layout model.
module tb_conv_sched;
    localparam int L     = 13;
    localparam int HCHAR = 22;
    localparam int VCHAR = 2;
    localparam int ADDRW = 10;
    localparam int WORDW = 10;
    localparam int WPR   = HCHAR / 4;
    localparam int SLOTS = WPR * VCHAR;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic vsync = 1'b1;
    logic busy, done, overrun;

    conv_sched_if #(.WORDW(WORDW), .ADDRW(ADDRW)) bus ();

    conv_sched #(
        .L(L), .WORDW(WORDW), .HCHAR(HCHAR), .VCHAR(VCHAR), .ADDRW(ADDRW)
    ) dut (
        .clk(clk), .RST(RST), .vsync(vsync), .bus(bus),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [9:0] mem [256];

    // Source bank: data only meaningful in the cycle after the read.
    always @(posedge clk)
        bus.src_data <= bus.src_rd ? mem[bus.src_addr] : 10'($urandom);

    function automatic logic [11:0] to_bcd(input logic [9:0] b);
        int v;
        v = int'(b);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign bus.bcd_dec = to_bcd(bus.bcd_bin);

    typedef struct {
        logic [9:0]  w;
        logic [11:0] codes;
    } vec_t;

    vec_t        tv [L];
    logic [11:0] exp_code [L];
    bit          written [1024];
    int          n_cmp, n_bad;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_codes(input int v);
        int hd, td, ud;
        if (v > 999) return 12'hEEE;
        hd = v / 100;
        td = (v / 10) % 10;
        ud = v % 10;
        return {(hd == 0) ? 4'hF : 4'(hd),
                (hd == 0 && td == 0) ? 4'hF : 4'(td),
                4'(ud)};
    endfunction

    function automatic int model_addr(input int k, input int j);
        int slot;
        slot = k % SLOTS;
        return (slot / WPR) * HCHAR + (slot % WPR) * 4 + j;
    endfunction

    task automatic load_random();
        int w;
        for (int k = 0; k < L; k++) begin
            if ($urandom_range(0, 3) == 0) w = int'($urandom_range(0, 1023));
            else w = int'($urandom_range(0, 120));
            mem[k] = 10'(w);
            exp_code[k] = model_codes(w);
        end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 3..5
    task automatic run_frame(input int rmode, input int ovr_at,
                             input int exp_ovr, output int stalls);
        int busy_n, done_n, done_c, rd_n, pa, pd, nib;
        bit hold, fin;
        int oa[$];
        int od[$];
        stalls = 0; busy_n = 0; done_n = 0; done_c = -1; rd_n = 0;
        hold = 0; fin = 0; pa = 0; pd = 0;
        vsync = 1'b0;
        bus.buf_ready = 1'b1;
        tick();
        vsync = 1'b1;
        for (int i = 0; i < 2000 && !fin; i++) begin
            tick();
            if (ovr_at >= 0 && i == ovr_at) vsync = 1'b0;
            if (ovr_at >= 0 && i == ovr_at + 1) vsync = 1'b1;
            case (rmode)
                0: bus.buf_ready = 1'b1;
                1: bus.buf_ready = $urandom_range(0, 3) != 0;
                default: bus.buf_ready = !(i >= 3 && i <= 5);
            endcase
            if (i == 0) begin
                chk("first_rd", int'(bus.src_rd), 1);
                chk("first_addr", int'(bus.src_addr), 0);
            end
            if (hold) begin
                chk("hold_wr", int'(bus.buf_wr), 1);
                chk("hold_addr", int'(bus.buf_addr), pa);
                chk("hold_data", int'(bus.buf_data), pd);
            end
            if (bus.src_rd) begin
                chk("src_addr", int'(bus.src_addr), rd_n);
                rd_n++;
            end
            if (bus.buf_wr && bus.buf_ready) begin
                oa.push_back(int'(bus.buf_addr));
                od.push_back(int'(bus.buf_data));
                written[bus.buf_addr] = 1'b1;
            end else if (bus.buf_wr) begin
                stalls++;
            end
            hold = bus.buf_wr && !bus.buf_ready;
            pa = int'(bus.buf_addr);
            pd = int'(bus.buf_data);
            if (done) begin
                done_n++;
                done_c = i;
            end
            if (busy) busy_n++;
            else fin = 1'b1;
        end
        chk("run_end", int'(fin), 1);
        chk("done_cnt", done_n, 1);
        chk("done_time", done_c, 6 * L + stalls);
        chk("busy_len", busy_n, 6 * L + 1 + stalls);
        chk("rd_cnt", rd_n, L);
        chk("wr_cnt", oa.size(), 4 * L);
        for (int k = 0; k < L; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < oa.size()) begin
                    nib = (j == 3) ? 15 : int'(exp_code[k][11 - 4 * j -: 4]);
                    chk("wr_addr", oa[4 * k + j], model_addr(k, j));
                    chk("wr_data", od[4 * k + j], nib);
                end
            end
        end
        chk("overrun", int'(overrun), exp_ovr);
    endtask

    initial begin
        int st;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;

        tv[0]  = '{10'd5,    12'hFF5};
        tv[1]  = '{10'd120,  12'h120};
        tv[2]  = '{10'd999,  12'h999};
        tv[3]  = '{10'd1023, 12'hEEE};
        tv[4]  = '{10'd0,    12'hFF0};
        tv[5]  = '{10'd10,   12'hF10};
        tv[6]  = '{10'd100,  12'h100};
        tv[7]  = '{10'd1000, 12'hEEE};
        tv[8]  = '{10'd9,    12'hFF9};
        tv[9]  = '{10'd99,   12'hF99};
        tv[10] = '{10'd101,  12'h101};
        tv[11] = '{10'd110,  12'h110};
        tv[12] = '{10'd500,  12'h500};

        RST = 1'b1;
        vsync = 1'b1;
        bus.buf_ready = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        repeat (4) tick();
        chk("rst_src_rd", int'(bus.src_rd), 0);
        chk("rst_src_addr", int'(bus.src_addr), 0);
        chk("rst_buf_wr", int'(bus.buf_wr), 0);
        chk("rst_buf_addr", int'(bus.buf_addr), 0);
        chk("rst_buf_data", int'(bus.buf_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);

        for (int k = 0; k < L; k++) begin
            mem[k] = tv[k].w;
            exp_code[k] = tv[k].codes;
        end
        run_frame(0, -1, 0, st);
        chk("no_stall", st, 0);

        run_frame(2, -1, 0, st);
        chk("stall_cnt", st, 3);

        repeat (4) begin
            load_random();
            run_frame(1, -1, 0, st);
        end

        load_random();
        run_frame(0, 7, 1, st);
        load_random();
        run_frame(1, -1, 1, st);

        for (int r = 0; r < VCHAR; r++)
            for (int c = WPR * 4; c < HCHAR; c++)
                chk("unused_col", int'(written[r * HCHAR + c]), 0);

        vsync = 1'b0;
        bus.buf_ready = 1'b1;
        tick();
        vsync = 1'b1;
        for (int i = 0; i <= 4; i++) tick();
        chk("mid_w0_wr", int'(bus.buf_wr), 1);
        chk("mid_w0_addr", int'(bus.buf_addr), 2);
        RST = 1'b1;
        tick();
        chk("mid_rst_wr", int'(bus.buf_wr), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovr", int'(overrun), 0);
        chk("mid_rst_addr", int'(bus.buf_addr), 0);
        RST = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
